// File: rtl/prbs_pattern_gen_pkg.sv
// Shared types and constants for the PRBS pattern generator: FSM state encoding,
// counter width and the second feedback tap for each supported PRBS order.
package prbs_pattern_gen_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // First tap is always the LFSR length; this returns the second one (1-based).
    function automatic int unsigned lfsr_tap2(input int unsigned len);
        case (len)
            7:       return 6;
            15:      return 14;
            23:      return 18;
            31:      return 28;
            default: return len - 1;
        endcase
    endfunction

endpackage

// File: rtl/prbs_pattern_gen_if.sv
// Control and stream signals of the PRBS pattern generator.
// master = stimulus/control side, slave = the generator itself.
interface prbs_pattern_gen_if;
    import prbs_pattern_gen_pkg::*;

    logic             start;
    logic             stop;
    logic             inject_req;
    logic             inject_ack;
    logic             pattern;
    logic             bit_valid;
    logic             tx_enable;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output start, stop, inject_req,
        input  inject_ack, pattern, bit_valid, tx_enable, bit_count
    );

    modport slave (
        input  start, stop, inject_req,
        output inject_ack, pattern, bit_valid, tx_enable, bit_count
    );

endinterface

// File: rtl/prbs_pattern_gen_lfsr.sv
// Fibonacci LFSR with synchronous seed load and shift enable; fb_c is the
// feedback bit that the next shift will insert at bit 0.
module prbs_pattern_gen_lfsr
    import prbs_pattern_gen_pkg::*;
#(
    parameter int unsigned     LEN  = 7,
    parameter logic [LEN-1:0]  SEED = '1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic shift,
    output logic fb_c
);
    localparam int unsigned T1 = LEN;
    localparam int unsigned T2 = lfsr_tap2(LEN);

    logic [LEN-1:0] lfsr_q;
    logic [LEN-1:0] lfsr_d;

    always_comb fb_c = lfsr_q[T1-1] ^ lfsr_q[T2-1];

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED;
        end else if (shift) begin
            lfsr_d = {lfsr_q[LEN-2:0], fb_c};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/prbs_pattern_gen.sv
// PRBS pattern generator: run-control FSM, bit-rate divider, saturating bit counter.
// Single-bit error injection is compiled in only when ERR_INJECT_EN is defined.
module prbs_pattern_gen
    import prbs_pattern_gen_pkg::*;
#(
    parameter int unsigned          LFSR_LEN = 7,
    parameter int unsigned          DIV      = 50,
    parameter logic [LFSR_LEN-1:0]  SEED     = '1
) (
    input  logic              clock,
    input  logic              reset,
    prbs_pattern_gen_if.slave bus
);
    localparam int unsigned      DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pattern_q, pattern_d;
    logic             bit_valid_q, bit_valid_d;
    logic             tx_enable_q, tx_enable_d;
    logic             inject_ack_q, inject_ack_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;

    logic lfsr_load;
    logic lfsr_shift;
    logic lfsr_fb;
    logic inj;

`ifdef ERR_INJECT_EN
    assign inj = bus.inject_req;
`else
    logic unused_inject_req;
    assign inj               = 1'b0;
    assign unused_inject_req = bus.inject_req;
`endif

    prbs_pattern_gen_lfsr #(
        .LEN  (LFSR_LEN),
        .SEED (SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .load  (lfsr_load),
        .shift (lfsr_shift),
        .fb_c  (lfsr_fb)
    );

    // Next-state, divider and bit generation; a cycle that leaves RUN never emits a bit.
    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        pattern_d    = pattern_q;
        bit_valid_d  = 1'b0;
        inject_ack_d = 1'b0;
        bit_count_d  = bit_count_q;
        lfsr_load    = 1'b0;
        lfsr_shift   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                lfsr_load   = 1'b1;
                div_cnt_d   = '0;
                bit_count_d = '0;
                pattern_d   = 1'b0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                end else if (!bus.stop) begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d    = '0;
                        lfsr_shift   = 1'b1;
                        pattern_d    = lfsr_fb ^ inj;
                        bit_valid_d  = 1'b1;
                        inject_ack_d = inj;
                        bit_count_d  = (bit_count_q == '1) ? bit_count_q
                                                           : bit_count_q + CNT_W'(1);
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.stop) begin
            state_d = ST_IDLE;
        end

        tx_enable_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= '0;
            pattern_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            tx_enable_q  <= 1'b0;
            inject_ack_q <= 1'b0;
            bit_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            pattern_q    <= pattern_d;
            bit_valid_q  <= bit_valid_d;
            tx_enable_q  <= tx_enable_d;
            inject_ack_q <= inject_ack_d;
            bit_count_q  <= bit_count_d;
        end
    end

    assign bus.pattern    = pattern_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.tx_enable  = tx_enable_q;
    assign bus.inject_ack = inject_ack_q;
    assign bus.bit_count  = bit_count_q;

endmodule
